uart_rx_oversampled: RTL and testbench
======================================

Name: uart_rx_oversampled

Overview:
- UART receiver that consumes the 16x oversampling tick from the baud rate generator and deserializes asynchronous 8N1 frames arriving on the ESP8266 link.
- Synchronizes RX, validates the start bit at mid-bit, samples data LSB-first at bit centres, and checks the stop bit.
- Reports each completed byte with a one-cycle VALID strobe, or a bad frame with a FRAME_ERR strobe.
- Sits between the pin-level RX line and the byte-level consumer logic on the FPGA.

Parameters:
- DATA_BITS, 8, number of data bits per frame (LSB first); legal range 5..9.
- BAUDCLOCK, 16, BCLK ticks per bit period; must equal the generator's BAUDCLOCK; even, >= 4.

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous active-high reset.
- BCLK  input  1  oversampling tick, one CLK cycle wide, BAUDCLOCK ticks per bit.
- RX  input  1  asynchronous serial line; idle high.
- DATA  output  DATA_BITS  last correctly received byte; holds its value until the next good frame.
- VALID  output  1  one-CLK pulse: DATA was updated with a good frame.
- FRAME_ERR  output  1  one-CLK pulse: stop bit was sampled low.
- BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous) values:
  - State = IDLE; DATA = 0; VALID = 0; FRAME_ERR = 0; BUSY = 0.
  - Both synchronizer flops = 1; tick counter = 0; bit index = 0; shift register = 0.
- RX synchronizer: 2-flop, clocked every CLK cycle. All decisions use the second-flop value (rx_s), which lags RX by 2 CLK.
- The tick counter (width clog2(BAUDCLOCK)) and all state transitions advance only on CLK edges where BCLK = 1. Exception: VALID and FRAME_ERR self-clear on every CLK edge.
- States:
  - IDLE: on a tick with rx_s = 0 -> START, counter = 0.
  - START:
    - On each tick, counter++.
    - On the tick where counter == BAUDCLOCK/2-1 (mid start bit):
      - rx_s = 0 -> DATA, counter = 0, bit index = 0.
      - rx_s = 1 -> IDLE. This is a glitch/false start; no strobe is raised.
  - DATA:
    - On each tick, counter++.
    - On the tick where counter == BAUDCLOCK-1: shift rx_s into the MSB end of the shift register (so the LSB arrives first), counter = 0, bit index++.
    - After DATA_BITS samples -> STOP.
  - STOP:
    - On the tick where counter == BAUDCLOCK-1, sample rx_s:
      - rx_s = 1: DATA <= shift register, VALID <= 1.
      - rx_s = 0: FRAME_ERR <= 1; DATA unchanged.
    - In both cases -> IDLE, counter = 0.
- Strobe latency: VALID and FRAME_ERR go high on the same CLK edge as the stop-bit sampling tick. They return low on the next CLK edge. They are never both high.
- Back-to-back frames: the receiver returns to IDLE at mid stop bit, so it can detect a start bit that immediately follows the stop bit. No frames are lost at full line rate.
- Break condition (RX held low): each stop bit samples low and produces FRAME_ERR. The receiver then re-enters START on the next tick while the line stays low.
- RX changes between BCLK ticks have no effect except through the synchronizer.
- BCLK stuck low: the receiver freezes in its current state. No timeout.
- Reset mid-frame: immediately returns to reset values. The partial byte is discarded and no strobe is raised.
- Counter width rule: the counter never exceeds BAUDCLOCK-1. Wrap is explicit (it is set to 0), not by overflow.

Test Plan:
- Setup for all scenarios: bench drives BCLK = 1 every 4th CLK (BAUDCLOCK=16, so 64 CLK per bit).
- Single byte: send 0xA5 as 8N1 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> exactly one VALID pulse, DATA = 0xA5, FRAME_ERR never high, BUSY low after mid stop bit.
- Back-to-back: send 0x00, 0xFF, 0x55 with no idle gap -> three VALID pulses, DATA = 0x00, then 0xFF, then 0x55; no FRAME_ERR.
- False start: RX low for 16 CLK (4 ticks), then high -> returns to IDLE by mid start bit; no VALID, no FRAME_ERR; DATA keeps its prior value.
- Frame error: send 0x3C with stop bit = 0 -> one FRAME_ERR pulse, no VALID, DATA keeps the previous value (0x55 from the prior test); a following good frame 0x81 gives VALID and DATA = 0x81.
- Reset mid-frame: assert RST during bit 3 of 0xC3 -> all outputs go to 0 asynchronously, state IDLE; after release, a clean 0x7E frame gives VALID with DATA = 0x7E.
- Baud tolerance: send 0x96 with the bit period stretched +3% (66 CLK/bit) and shrunk −3% (62 CLK/bit) -> DATA = 0x96, VALID, no FRAME_ERR in both cases.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_oversampled
// Description : 8N1-style UART receiver driven by an external oversampling
//               tick; validates the start bit, samples the data bits at their
//               centres and checks the stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_oversampled #(
    parameter int DATA_BITS = 8,
    parameter int BAUDCLOCK = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 BCLK,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] DATA,
    output logic                 VALID,
    output logic                 FRAME_ERR,
    output logic                 BUSY
);

    localparam int c_CNT_W = $clog2(BAUDCLOCK);
    localparam int c_IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [c_CNT_W-1:0] c_HALF_BIT = c_CNT_W'(BAUDCLOCK / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_BIT = c_CNT_W'(BAUDCLOCK - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_BIT = c_IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;

    // Two-flop synchronizer; both flops reset to the idle line level.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            DATA      <= '0;
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
            if (BCLK) begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_rx_s) begin
                            r_state <= S_START;
                            r_cnt   <= '0;
                            BUSY    <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (r_cnt == c_HALF_BIT) begin
                            r_cnt <= '0;
                            if (!r_rx_s) begin
                                r_state   <= S_DATA;
                                r_bit_idx <= '0;
                            end else begin
                                // Line went back high before mid start bit: a glitch.
                                r_state <= S_IDLE;
                                BUSY    <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                    S_DATA: begin
                        if (r_cnt == c_FULL_BIT) begin
                            r_cnt     <= '0;
                            r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                            r_bit_idx <= r_bit_idx + c_IDX_W'(1);
                            if (r_bit_idx == c_LAST_BIT) begin
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                    S_STOP: begin
                        if (r_cnt == c_FULL_BIT) begin
                            // Leaving at mid stop bit lets an immediately following start bit be caught.
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                            BUSY    <= 1'b0;
                            if (r_rx_s) begin
                                DATA  <= r_shift;
                                VALID <= 1'b1;
                            end else begin
                                FRAME_ERR <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        BUSY    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_oversampled
// Description : Scoreboard bench for uart_rx_oversampled (BAUDCLOCK=16, tick
//               every 4th CLK, 64 CLK per nominal bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_oversampled;

    logic       CLK;
    logic       RST;
    logic       BCLK;
    logic       RX;
    logic [7:0] DATA;
    logic       VALID;
    logic       FRAME_ERR;
    logic       BUSY;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] last_good = 8'h00;

    uart_rx_oversampled #(
        .DATA_BITS(8),
        .BAUDCLOCK(16)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .BCLK     (BCLK),
        .RX       (RX),
        .DATA     (DATA),
        .VALID    (VALID),
        .FRAME_ERR(FRAME_ERR),
        .BUSY     (BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        BCLK = 1'b0;
        forever begin
            repeat (3) @(negedge CLK);
            BCLK = 1'b1;
            @(negedge CLK);
            BCLK = 1'b0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pushes the expected strobe, then drives one frame with the given bit length in CLK cycles.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int bitlen);
        exp_t e;
        e.err  = ~stop;
        e.data = stop ? d : last_good;
        if (stop) last_good = d;
        sb.push_back(e);
        @(negedge CLK);
        RX = 1'b0;
        wait_clk(bitlen);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            wait_clk(bitlen);
        end
        RX = stop;
        wait_clk(bitlen);
        RX = 1'b1;
    endtask

    task automatic drain_check(input string name);
        chk(name, sb.size(), 0);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (VALID || FRAME_ERR) begin
            checks++;
            if (VALID && FRAME_ERR) begin
                errors++;
                $display("FAIL strobe_overlap: VALID=%b FRAME_ERR=%b expected one-hot", VALID, FRAME_ERR);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: VALID=%b FRAME_ERR=%b DATA=%0h expected no strobe",
                         VALID, FRAME_ERR, DATA);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (FRAME_ERR !== e.err || DATA !== e.data) begin
                    errors++;
                    $display("FAIL strobe_compare: got err=%b data=%0h expected err=%b data=%0h",
                             FRAME_ERR, DATA, e.err, e.data);
                end
            end
        end
    end

    initial begin
        logic [7:0] c3;
        RST = 1'b1;
        RX  = 1'b1;
        wait_clk(3);
        chk("reset_DATA", DATA, 8'h00);
        chk("reset_VALID", VALID, 1'b0);
        chk("reset_FRAME_ERR", FRAME_ERR, 1'b0);
        chk("reset_BUSY", BUSY, 1'b0);
        RST = 1'b0;
        wait_clk(20);

        // Single byte
        send_frame(8'hA5, 1'b1, 64);
        chk("a5_busy_after_stop", BUSY, 1'b0);
        chk("a5_data", DATA, 8'hA5);
        wait_clk(64);
        drain_check("a5_drain");

        // Back-to-back frames with no idle gap
        send_frame(8'h00, 1'b1, 64);
        send_frame(8'hFF, 1'b1, 64);
        send_frame(8'h55, 1'b1, 64);
        wait_clk(64);
        drain_check("b2b_drain");
        chk("b2b_data", DATA, 8'h55);

        // False start: 16 CLK low pulse
        @(negedge CLK);
        RX = 1'b0;
        wait_clk(16);
        RX = 1'b1;
        wait_clk(8);
        chk("false_start_busy", BUSY, 1'b1);
        wait_clk(64);
        chk("false_start_idle", BUSY, 1'b0);
        chk("false_start_data", DATA, 8'h55);
        drain_check("false_start_drain");

        // Framing error, then recovery
        send_frame(8'h3C, 1'b0, 64);
        wait_clk(128);
        drain_check("ferr_drain");
        chk("ferr_data_kept", DATA, 8'h55);
        send_frame(8'h81, 1'b1, 64);
        wait_clk(64);
        drain_check("recover_drain");
        chk("recover_data", DATA, 8'h81);

        // Reset during bit 3 of 0xC3
        c3 = 8'hC3;
        @(negedge CLK);
        RX = 1'b0;
        wait_clk(64);
        for (int i = 0; i < 3; i++) begin
            RX = c3[i];
            wait_clk(64);
        end
        RX = c3[3];
        wait_clk(32);
        chk("midframe_busy", BUSY, 1'b1);
        RST = 1'b1;
        #1;
        chk("midrst_DATA", DATA, 8'h00);
        chk("midrst_VALID", VALID, 1'b0);
        chk("midrst_FRAME_ERR", FRAME_ERR, 1'b0);
        chk("midrst_BUSY", BUSY, 1'b0);
        last_good = 8'h00;
        wait_clk(5);
        RX  = 1'b1;
        RST = 1'b0;
        wait_clk(130);
        drain_check("midrst_no_strobe");
        send_frame(8'h7E, 1'b1, 64);
        wait_clk(64);
        drain_check("post_rst_drain");
        chk("post_rst_data", DATA, 8'h7E);

        // Baud tolerance: +3% and -3% bit periods
        send_frame(8'h96, 1'b1, 66);
        wait_clk(128);
        drain_check("slow_drain");
        chk("slow_data", DATA, 8'h96);
        send_frame(8'h96, 1'b1, 62);
        wait_clk(128);
        drain_check("fast_drain");
        chk("fast_data", DATA, 8'h96);
        chk("final_busy", BUSY, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
